// File: rtl/proc_pkg.sv
// Processor-wide pipeline constants and the payload layout at each stage boundary.
// Keeping the packed structs here fixes the field concatenation order in one place.
package proc_pkg;

    localparam int MAX_PIPE_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_dec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        wb_en;
        logic        branch;
    } dec_ex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic [2:0]  mem_op;
        logic        wb_en;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        wb_en;
    } mem_wb_t;

    localparam int IF_DEC_W = $bits(if_dec_t);
    localparam int DEC_EX_W = $bits(dec_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_slot.sv
// One pipeline register slot: valid bit plus payload, with load enable, clear
// and forced-zero payload whenever the incoming entry is a bubble.
module pipe_slot
    import proc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Clear wins over load; a loaded bubble always carries a zero payload (NOP)
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr_i) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (load_i) begin
            valid_d = valid_i;
            data_d  = valid_i ? data_i : '0;
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    // Slot state register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_ctl.sv
// Parametrised stage register: DEPTH slots with a backward ready chain so that
// bubbles collapse while the output is stalled, plus flush and occupancy tracking.
module pipe_stage_ctl
    import proc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Stall,
    input  logic             Flush,
    input  logic             InValid,
    input  logic [WIDTH-1:0] In,
    output logic             InReady,
    output logic             OutValid,
    output logic [WIDTH-1:0] Out,
    output logic [OCC_W-1:0] Occupancy
);

    logic [DEPTH:0]              rdy_s;
    logic [DEPTH-1:0]            slot_v_s;
    logic [DEPTH-1:0][WIDTH-1:0] slot_d_s;
    logic [DEPTH-1:0]            src_v_s;
    logic [DEPTH-1:0][WIDTH-1:0] src_d_s;
    logic                        accept_s;
    logic                        consume_s;
    logic [OCC_W-1:0]            occ_q;
    logic [OCC_W-1:0]            occ_d;

    // A slot may load when it is empty or the slot after it is moving
    always_comb begin
        rdy_s        = '0;
        rdy_s[DEPTH] = ~Stall;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy_s[i] = ~slot_v_s[i] | rdy_s[i+1];
        end
    end

    // Each slot is fed by its upstream neighbour; slot 0 by the stage input
    always_comb begin
        src_v_s    = '0;
        src_d_s    = '0;
        src_v_s[0] = InValid;
        src_d_s[0] = In;
        for (int i = 1; i < DEPTH; i++) begin
            src_v_s[i] = slot_v_s[i-1];
            src_d_s[i] = slot_d_s[i-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        pipe_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk_i   (Clock),
            .rst_n_i (nReset),
            .clr_i   (Flush),
            .load_i  (rdy_s[g]),
            .valid_i (src_v_s[g]),
            .data_i  (src_d_s[g]),
            .valid_o (slot_v_s[g]),
            .data_o  (slot_d_s[g])
        );
    end

    assign InReady   = rdy_s[0] & ~Flush;
    assign OutValid  = slot_v_s[DEPTH-1];
    assign Out       = slot_d_s[DEPTH-1];
    assign accept_s  = InValid & InReady;
    assign consume_s = OutValid & ~Stall;

    // Occupancy moves by at most one per cycle; flush empties it outright
    always_comb begin
        occ_d = occ_q;
        if (Flush) begin
            occ_d = '0;
        end else begin
            case ({accept_s, consume_s})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // Occupancy register, updated on the same edge as the slots
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign Occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_ctl.sv
// Directed bench for pipe_stage_ctl: a DEPTH=3 instance for streaming, bubble
// collapse, stall and flush, and a DEPTH=1 instance for mid-stream reset.
module tb_pipe_stage_ctl;

    logic        clk;
    int          vectors;
    int          miscompares;

    logic        rst3, stall3, flush3, iv3, ir3, ov3;
    logic [31:0] in3, out3;
    logic [1:0]  occ3;

    logic        rst1, stall1, flush1, iv1, ir1, ov1;
    logic [31:0] in1, out1;
    logic [0:0]  occ1;

    pipe_stage_ctl #(.WIDTH(32), .DEPTH(3)) dut3 (
        .Clock(clk), .nReset(rst3), .Stall(stall3), .Flush(flush3),
        .InValid(iv3), .In(in3), .InReady(ir3), .OutValid(ov3),
        .Out(out3), .Occupancy(occ3)
    );

    pipe_stage_ctl #(.WIDTH(32), .DEPTH(1)) dut1 (
        .Clock(clk), .nReset(rst1), .Stall(stall1), .Flush(flush1),
        .InValid(iv1), .In(in1), .InReady(ir1), .OutValid(ov1),
        .Out(out1), .Occupancy(occ1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string tag, input logic v, input logic [31:0] d, input logic [1:0] o);
        chk({tag, "_ov"}, 32'(ov3), 32'(v));
        chk({tag, "_out"}, out3, d);
        chk({tag, "_occ"}, 32'(occ3), 32'(o));
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst3 = 1'b0; stall3 = 1'b0; flush3 = 1'b0; iv3 = 1'b0; in3 = 32'h0;
        rst1 = 1'b0; stall1 = 1'b0; flush1 = 1'b0; iv1 = 1'b0; in1 = 32'h0;

        // reset state
        cyc();
        chk3("reset", 1'b0, 32'h0, 2'd0);
        chk("reset_ir", 32'(ir3), 32'h1);
        chk("reset1_ov", 32'(ov1), 32'h0);
        chk("reset1_occ", 32'(occ1), 32'h0);
        rst3 = 1'b1; rst1 = 1'b1;

        // streaming 0x11, 0x22, 0x33
        iv3 = 1'b1; in3 = 32'h11; cyc(); chk3("st_a", 1'b0, 32'h0, 2'd1);
        in3 = 32'h22;              cyc(); chk3("st_b", 1'b0, 32'h0, 2'd2);
        in3 = 32'h33;              cyc(); chk3("st_c", 1'b1, 32'h11, 2'd3);
        iv3 = 1'b0; in3 = 32'h0;   cyc(); chk3("st_d", 1'b1, 32'h22, 2'd2);
        cyc(); chk3("st_e", 1'b1, 32'h33, 2'd1);
        cyc(); chk3("st_f", 1'b0, 32'h0, 2'd0);

        // bubble collapse under stall
        stall3 = 1'b1; iv3 = 1'b1; in3 = 32'hA1; #1;
        chk("bc_ir0", 32'(ir3), 32'h1);
        cyc(); chk3("bc_1", 1'b0, 32'h0, 2'd1);
        iv3 = 1'b0; in3 = 32'h0; #1;
        chk("bc_ir1", 32'(ir3), 32'h1);
        cyc(); chk3("bc_2", 1'b0, 32'h0, 2'd1);
        iv3 = 1'b1; in3 = 32'hA2; #1;
        chk("bc_ir2", 32'(ir3), 32'h1);
        cyc(); chk3("bc_3", 1'b1, 32'hA1, 2'd2);
        in3 = 32'hA3; #1;
        chk("bc_ir3", 32'(ir3), 32'h1);
        cyc(); chk3("bc_4", 1'b1, 32'hA1, 2'd3);
        chk("bc_ir_full", 32'(ir3), 32'h0);
        stall3 = 1'b0; iv3 = 1'b0; in3 = 32'h0;
        cyc(); chk3("bc_dr1", 1'b1, 32'hA2, 2'd2);
        cyc(); chk3("bc_dr2", 1'b1, 32'hA3, 2'd1);
        cyc(); chk3("bc_dr3", 1'b0, 32'h0, 2'd0);

        // stall with a full pipe: slot2=0x3, slot1=0x2, slot0=0x1
        iv3 = 1'b1; in3 = 32'h3; cyc();
        in3 = 32'h2; cyc();
        in3 = 32'h1; cyc(); chk3("sf_fill", 1'b1, 32'h3, 2'd3);
        stall3 = 1'b1; in3 = 32'hFF; #1;
        chk("sf_ir_now", 32'(ir3), 32'h0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk3("sf_hold", 1'b1, 32'h3, 2'd3);
            chk("sf_hold_ir", 32'(ir3), 32'h0);
        end
        stall3 = 1'b0;
        cyc(); chk3("sf_r1", 1'b1, 32'h2, 2'd3);
        iv3 = 1'b0; in3 = 32'h0;
        cyc(); chk3("sf_r2", 1'b1, 32'h1, 2'd2);
        cyc(); chk3("sf_r3", 1'b1, 32'hFF, 2'd1);
        cyc(); chk3("sf_r4", 1'b0, 32'h0, 2'd0);

        // flush together with stall and a valid input
        iv3 = 1'b1; in3 = 32'hC1; cyc();
        in3 = 32'hC2; cyc();
        in3 = 32'hC3; cyc(); chk3("fl_fill", 1'b1, 32'hC1, 2'd3);
        flush3 = 1'b1; stall3 = 1'b1; in3 = 32'hBEEF; #1;
        chk("fl_ir", 32'(ir3), 32'h0);
        cyc(); chk3("fl_empty", 1'b0, 32'h0, 2'd0);
        flush3 = 1'b0; stall3 = 1'b0; iv3 = 1'b0; in3 = 32'h0; #1;
        chk("fl_ir_after", 32'(ir3), 32'h1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk3("fl_nobeef", 1'b0, 32'h0, 2'd0);
        end

        // DEPTH=1: plain register, reset mid-stream
        iv1 = 1'b1; in1 = 32'h5A; cyc();
        chk("d1_ov", 32'(ov1), 32'h1);
        chk("d1_out", out1, 32'h5A);
        chk("d1_occ", 32'(occ1), 32'h1);
        rst1 = 1'b0; in1 = 32'h77; cyc();
        chk("d1_rst_ov", 32'(ov1), 32'h0);
        chk("d1_rst_out", out1, 32'h0);
        chk("d1_rst_occ", 32'(occ1), 32'h0);
        rst1 = 1'b1; cyc();
        chk("d1_res_ov", 32'(ov1), 32'h1);
        chk("d1_res_out", out1, 32'h77);
        chk("d1_res_occ", 32'(occ1), 32'h1);
        iv1 = 1'b0; in1 = 32'h0; cyc();
        chk("d1_drain_ov", 32'(ov1), 32'h0);
        chk("d1_drain_out", out1, 32'h0);
        chk("d1_drain_occ", 32'(occ1), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
